// File: rtl/mux_pkg.sv
// Shared constants and types for the round-robin registered mux.
// Mode encodings, output-register state view and an index-width helper.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // A single channel still needs a 1-bit index, so never return 0.
  function automatic int clog2_min1(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_pipe_rr_pick.sv
// Rotating-priority search: the first set request at or after ptr, wrapping.
// Purely combinational; distance from ptr is computed with an explicit wrap.
module rr_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]                   req,
  input  logic [clog2_min1(CHANNELS)-1:0]       ptr,
  output logic [clog2_min1(CHANNELS)-1:0]       idx,
  output logic                                  found
);

  localparam int SEL_W = clog2_min1(CHANNELS);

  int ptr_i;
  int best_d;
  int d;

  // Smallest forward distance from ptr among requesting channels wins.
  always_comb begin
    idx    = '0;
    found  = |req;
    ptr_i  = int'(ptr);
    best_d = CHANNELS;
    d      = 0;
    if (ptr_i >= CHANNELS) ptr_i = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      d = i - ptr_i;
      if (d < 0) d = d + CHANNELS;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        idx    = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel registered mux with direct-select and round-robin modes.
// Valid/ready on every input and on a single-entry output register.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mode,
  input  logic [clog2_min1(CHANNELS)-1:0]   sel,
  input  logic [CHANNELS*WIDTH-1:0]         in_data,
  input  logic [CHANNELS-1:0]               in_valid,
  output logic [CHANNELS-1:0]               in_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [clog2_min1(CHANNELS)-1:0]   out_chan,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int SEL_W = clog2_min1(CHANNELS);

  out_state_t        state, state_next;
  logic [SEL_W-1:0]  rr_ptr, rr_ptr_next;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_found;
  logic [SEL_W-1:0]  grant;
  logic              gvalid;
  logic              direct_valid;
  logic [WIDTH-1:0]  grant_data;
  logic              load_en;
  logic              transfer;

  rr_pick #(.CHANNELS(CHANNELS)) u_rr_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign out_valid = (state == ST_FULL);
  assign load_en   = !out_valid || out_ready;

  // Grant selection; an out-of-range sel simply matches no channel.
  always_comb begin
    direct_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) direct_valid = in_valid[i];
    end
    if (mode == MODE_RR) begin
      grant  = rr_idx;
      gvalid = rr_found;
    end else begin
      grant  = sel;
      gvalid = direct_valid;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !rst && load_en && gvalid && (grant == SEL_W'(i));
    end
  end

  assign transfer = load_en && gvalid;

  // Pointer only advances on RR transfers so a DIRECT interlude keeps fairness.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (transfer && (mode == MODE_RR)) begin
      if (grant == SEL_W'(CHANNELS - 1)) rr_ptr_next = '0;
      else                               rr_ptr_next = grant + SEL_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (gvalid)                 state_next = ST_FULL;
      ST_FULL:  if (out_ready && !gvalid)   state_next = ST_EMPTY;
      default:                              state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_chan <= '0;
    end else if (transfer) begin
      out_data <= grant_data;
      out_chan <= grant;
    end
  end

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed scenarios plus a randomized run against a queue-free behavioural model.
module tb_mux_rr_pipe;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int SW = 2;

  logic            clk;
  logic            rst;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [C*W-1:0]  in_data;
  logic [C-1:0]    in_valid;
  logic [C-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  int n_checks;
  int n_fail;

  // Behavioural model state
  bit        m_valid;
  bit [W-1:0] m_data;
  int        m_chan;
  int        m_ptr;

  mux_rr_pipe #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_chan(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  // Grant derived from the rules: direct index or first valid scanning forward from the pointer.
  function automatic void model_grant(output int g, output bit gv);
    g  = 0;
    gv = 0;
    if (mode == 1'b0) begin
      g = int'(sel);
      gv = (g < C) ? in_valid[g] : 1'b0;
    end else begin
      for (int k = 0; k < C; k++) begin
        int c;
        c = (m_ptr + k) % C;
        if (!gv && in_valid[c]) begin
          gv = 1;
          g  = c;
        end
      end
    end
  endfunction

  function automatic logic [C-1:0] model_ready();
    int g;
    bit gv;
    logic [C-1:0] r;
    model_grant(g, gv);
    r = '0;
    if (!rst && (!m_valid || out_ready) && gv) r[g] = 1'b1;
    return r;
  endfunction

  function automatic void model_clock();
    int g;
    bit gv;
    model_grant(g, gv);
    if (rst) begin
      m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (gv) begin
        m_data = in_data[g*W +: W];
        m_chan = g;
        if (mode == 1'b1) m_ptr = (g + 1) % C;
      end
      m_valid = gv;
    end
  endfunction

  task automatic test_reset();
    rst = 1; mode = 1; sel = 0; in_valid = 4'b1111; out_ready = 1;
    in_data = 32'h44332211;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL reset_in_ready got=%b exp=0000", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, out_chan);
      end
    end
    rst = 0; in_valid = 0;
    tick();
  endtask

  task automatic test_direct();
    mode = 0; sel = 2; in_valid = 4'b0100; out_ready = 1;
    in_data = '0; set_chan(2, 8'hA5);
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("[TB] FAIL direct_ready got=%b exp=0100", in_ready);
    end
    tick();
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL direct_out got v=%b d=%h c=%0d exp v=1 d=a5 c=2", out_valid, out_data, out_chan);
    end
    tick();
  endtask

  task automatic test_rr_full();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    in_data = 32'hD3C2B1A0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || int'(out_chan) != exp_seq[i]) begin
        n_fail++;
        $display("[TB] FAIL rr_seq[%0d] got v=%b c=%0d exp v=1 c=%0d", i, out_valid, out_chan, exp_seq[i]);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_rr_sparse_stall();
    int exp_seq[4] = '{1, 3, 1, 3};
    rst = 1; tick(); rst = 0;
    mode = 1; in_valid = 4'b1010; out_ready = 1;
    in_data = 32'h33221100;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (int'(out_chan) != exp_seq[i] || out_data !== in_data[exp_seq[i]*W +: W]) begin
        n_fail++;
        $display("[TB] FAIL rr_sparse[%0d] got c=%0d d=%h exp c=%0d", i, out_chan, out_data, exp_seq[i]);
      end
    end
    out_ready = 0;
    in_data = 32'hEEDDCCBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL stall_ready got=%b exp=0000", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_data !== 8'h33) begin
        n_fail++;
        $display("[TB] FAIL stall_hold got v=%b c=%0d d=%h exp v=1 c=3 d=33", out_valid, out_chan, out_data);
      end
    end
    out_ready = 1;
    tick();
    n_checks++;
    if (out_chan !== 2'd1 || out_data !== 8'hCC) begin
      n_fail++; $display("[TB] FAIL stall_resume got c=%0d d=%h exp c=1 d=cc", out_chan, out_data);
    end
  endtask

  task automatic test_direct_invalid();
    mode = 0; sel = 3; in_valid = 4'b0111; out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL dir_invalid_ready got=%b exp=0000", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_chan !== 2'd1 || out_data !== 8'hCC) begin
      n_fail++;
      $display("[TB] FAIL dir_invalid_drain got v=%b c=%0d d=%h exp v=0 c=1 d=cc", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_reset_while_stalled();
    mode = 1; in_valid = 4'b0100; out_ready = 1;
    in_data = 32'h00000000; set_chan(2, 8'h5A);
    tick();
    out_ready = 0; in_valid = 4'b1111; in_data = 32'h77665544;
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_stall got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, out_chan);
    end
    out_ready = 1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h44) begin
      n_fail++;
      $display("[TB] FAIL rst_ptr got v=%b c=%0d d=%h exp v=1 c=0 d=44", out_valid, out_chan, out_data);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic [C-1:0] exp_ready;
    rst = 1;
    model_clock();
    tick();
    rst = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rst       = ($urandom_range(0, 31) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, C - 1));
      in_valid  = C'($urandom);
      in_data   = (C*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = model_ready();
      n_checks++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("[TB] FAIL rand_ready[%0d] got=%b exp=%b", cyc, in_ready, exp_ready);
      end
      model_clock();
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_data !== m_data || int'(out_chan) != m_chan) begin
        n_fail++;
        $display("[TB] FAIL rand_out[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                 cyc, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
    rst = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
    rst = 1; mode = 0; sel = 0; in_data = '0; in_valid = '0; out_ready = 0;
    test_reset();
    test_direct();
    test_rr_full();
    test_rr_sparse_stall();
    test_direct_invalid();
    test_reset_while_stalled();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
